// File: rtl/c2p_pkg.sv
// c2p_pkg: shared sizing and state encoding for the cartesian-to-polar slice
// scheduler.
//   Geometry:  NO_ARM_LED, NO_DELTA_INTERVALS, RGB_SIZE, DATA_WIDTH
//   Derived:   LPW (LEDs per word), WPS (words per slice), SLICE_W, OUT_DIM
//   Encoding:  conv_state_t (C_IDLE, C_CLR, C_RUN)
//   Helper:    next_idx() advances the interval counter with wrap.
package c2p_pkg;

  localparam int NO_ARM_LED         = 32;
  localparam int NO_DELTA_INTERVALS = 18;
  localparam int RGB_SIZE           = 8;
  localparam int DATA_WIDTH         = 32;

  localparam int LPW     = DATA_WIDTH / RGB_SIZE;
  localparam int WPS     = NO_ARM_LED / LPW;
  localparam int SLICE_W = NO_ARM_LED * RGB_SIZE;
  localparam int OUT_DIM = NO_DELTA_INTERVALS * SLICE_W;

  localparam int IDX_W  = $clog2(NO_DELTA_INTERVALS);
  localparam int WCNT_W = (WPS > 1) ? $clog2(WPS) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NO_DELTA_INTERVALS - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WPS - 1);

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_CLR  = 2'd1,
    C_RUN  = 2'd2
  } conv_state_t;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/c2p_slice_streamer.sv
// c2p_slice_streamer: holds a private copy of one arm slice and streams it to
// the LED driver as DATA_WIDTH words, lowest LED in the lowest byte.
//   clock, resetn      clock and async active-low reset
//   launch             request to start a slice (from the interval logic)
//   slice_in           slice contents to copy on an accepted launch
//   err_clr            clears the sticky overrun flag
//   led_tdata/tvalid/tlast, led_tready   LED word stream handshake
//   overrun            sticky: a launch arrived while a slice was in flight
module c2p_slice_streamer
  import c2p_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  launch,
  input  logic [SLICE_W-1:0]    slice_in,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] led_tdata,
  output logic                  led_tvalid,
  output logic                  led_tlast,
  input  logic                  led_tready,
  output logic                  overrun
);

  logic [SLICE_W-1:0] slice_reg;
  logic [WCNT_W-1:0]  word_cnt;
  logic               busy;
  logic               drop;

  // Busy through the cycle that accepts the last word; a launch there is
  // dropped, one on the following cycle is taken.
  assign busy = led_tvalid;
  assign drop = launch & busy;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      slice_reg  <= '0;
      word_cnt   <= '0;
      led_tvalid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (led_tvalid) begin
        if (led_tready) begin
          if (word_cnt == LAST_WORD) begin
            led_tvalid <= 1'b0;
            word_cnt   <= '0;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end
      end else if (launch) begin
        slice_reg  <= slice_in;
        word_cnt   <= '0;
        led_tvalid <= 1'b1;
      end

      // A drop in the same cycle as err_clr leaves the flag set.
      if (drop)
        overrun <= 1'b1;
      else if (err_clr)
        overrun <= 1'b0;
    end
  end

  assign led_tdata = slice_reg[word_cnt*DATA_WIDTH +: DATA_WIDTH];
  assign led_tlast = led_tvalid & (word_cnt == LAST_WORD);

endmodule

// File: rtl/c2p_slice_scheduler.sv
// c2p_slice_scheduler: sequences the get_map conversion, double-buffers the
// polar frame and launches one arm slice per angular interval.
//   clock, resetn                   clock and async active-low reset
//   frame_req                       pulse: convert a new frame
//   map_resetn, map_inp_valid       control to get_map (synchronous reset)
//   map_out_valid, map_out_image    result from get_map
//   index_pulse                     arm at interval 0 (frame swap point)
//   angle_tick                      arm advanced one interval
//   led_tdata/tvalid/tready/tlast   LED word stream
//   conv_busy                       conversion in progress
//   frame_loaded                    front buffer valid
//   overrun, err_clr                sticky dropped-launch flag and its clear
//
// state  | meaning
// C_IDLE | waiting for frame_req with an empty back buffer
// C_CLR  | map_resetn low for one cycle to clear get_map
// C_RUN  | map_inp_valid high until get_map returns the image
module c2p_slice_scheduler
  import c2p_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  frame_req,
  output logic                  map_resetn,
  output logic                  map_inp_valid,
  input  logic                  map_out_valid,
  input  logic [OUT_DIM-1:0]    map_out_image,
  input  logic                  index_pulse,
  input  logic                  angle_tick,
  output logic [DATA_WIDTH-1:0] led_tdata,
  output logic                  led_tvalid,
  input  logic                  led_tready,
  output logic                  led_tlast,
  output logic                  conv_busy,
  output logic                  frame_loaded,
  output logic                  overrun,
  input  logic                  err_clr
);

  conv_state_t        state;
  logic [OUT_DIM-1:0] back;
  logic [OUT_DIM-1:0] front;
  logic               back_full;
  logic               front_valid;
  logic [IDX_W-1:0]   idx;

  logic               swap;
  logic               launch;
  logic [IDX_W-1:0]   launch_idx;
  logic [OUT_DIM-1:0] slice_src;
  logic [SLICE_W-1:0] launch_slice;

  // A swap on the index pulse makes the new frame visible to slice 0 in the
  // same cycle, so the slice is read from back rather than the old front.
  assign swap         = index_pulse & back_full;
  assign launch_idx   = index_pulse ? '0 : next_idx(idx);
  assign launch       = (index_pulse | angle_tick) & (front_valid | swap);
  assign slice_src    = swap ? back : front;
  assign launch_slice = slice_src[launch_idx*SLICE_W +: SLICE_W];
  assign frame_loaded = front_valid;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= C_IDLE;
      map_resetn    <= 1'b0;
      map_inp_valid <= 1'b0;
      conv_busy     <= 1'b0;
      back          <= '0;
      back_full     <= 1'b0;
      front         <= '0;
      front_valid   <= 1'b0;
    end else begin
      case (state)
        C_IDLE: begin
          map_resetn <= 1'b1;
          if (frame_req && !back_full) begin
            state      <= C_CLR;
            map_resetn <= 1'b0;
            conv_busy  <= 1'b1;
          end
        end
        C_CLR: begin
          // Any map_out_valid seen here is left over from the previous run.
          state         <= C_RUN;
          map_resetn    <= 1'b1;
          map_inp_valid <= 1'b1;
        end
        C_RUN: begin
          if (map_out_valid) begin
            back          <= map_out_image;
            back_full     <= 1'b1;
            map_inp_valid <= 1'b0;
            conv_busy     <= 1'b0;
            state         <= C_IDLE;
          end
        end
        default: begin
          state         <= C_IDLE;
          map_resetn    <= 1'b1;
          map_inp_valid <= 1'b0;
          conv_busy     <= 1'b0;
        end
      endcase

      // back_full is only set while in C_RUN, where it is already 0, so the
      // capture and the swap never collide.
      if (swap) begin
        front       <= back;
        front_valid <= 1'b1;
        back_full   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      idx <= '0;
    else if (index_pulse)
      idx <= '0;
    else if (angle_tick)
      idx <= next_idx(idx);
  end

  c2p_slice_streamer u_streamer (
    .clock      (clock),
    .resetn     (resetn),
    .launch     (launch),
    .slice_in   (launch_slice),
    .err_clr    (err_clr),
    .led_tdata  (led_tdata),
    .led_tvalid (led_tvalid),
    .led_tlast  (led_tlast),
    .led_tready (led_tready),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_c2p_slice_scheduler.sv
module tb_c2p_slice_scheduler;
  import c2p_pkg::*;

  typedef logic [7:0] frame_t [NO_DELTA_INTERVALS][NO_ARM_LED];

  logic                  clock = 1'b0;
  logic                  resetn = 1'b0;
  logic                  frame_req = 1'b0;
  logic                  map_resetn;
  logic                  map_inp_valid;
  logic                  map_out_valid = 1'b0;
  logic [OUT_DIM-1:0]    map_out_image = '0;
  logic                  index_pulse = 1'b0;
  logic                  angle_tick = 1'b0;
  logic [DATA_WIDTH-1:0] led_tdata;
  logic                  led_tvalid;
  logic                  led_tready = 1'b0;
  logic                  led_tlast;
  logic                  conv_busy;
  logic                  frame_loaded;
  logic                  overrun;
  logic                  err_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state (values the DUT registers hold this cycle)
  frame_t     cur_pix;
  frame_t     m_back, m_front;
  logic [7:0] m_cur [NO_ARM_LED];
  int         m_phase, m_idx, m_rem, m_wc;
  bit         m_back_full, m_front_valid, m_overrun, m_mrst;

  c2p_slice_scheduler dut (
    .clock         (clock),
    .resetn        (resetn),
    .frame_req     (frame_req),
    .map_resetn    (map_resetn),
    .map_inp_valid (map_inp_valid),
    .map_out_valid (map_out_valid),
    .map_out_image (map_out_image),
    .index_pulse   (index_pulse),
    .angle_tick    (angle_tick),
    .led_tdata     (led_tdata),
    .led_tvalid    (led_tvalid),
    .led_tready    (led_tready),
    .led_tlast     (led_tlast),
    .conv_busy     (conv_busy),
    .frame_loaded  (frame_loaded),
    .overrun       (overrun),
    .err_clr       (err_clr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] exp_word(input int w);
    logic [DATA_WIDTH-1:0] r;
    for (int k = 0; k < LPW; k++)
      r[k*RGB_SIZE +: RGB_SIZE] = m_cur[w*LPW + k];
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_idx = 0; m_rem = 0; m_wc = 0;
    m_back_full = 0; m_front_valid = 0; m_overrun = 0; m_mrst = 0;
  endtask

  task automatic model_step();
    int nidx;
    bit launch, drop, bf_old;
    launch = 0; drop = 0; bf_old = m_back_full; nidx = m_idx;
    if (index_pulse || angle_tick) begin
      nidx = index_pulse ? 0 : (m_idx + 1) % NO_DELTA_INTERVALS;
      if (index_pulse && bf_old) begin
        m_front = m_back; m_front_valid = 1; m_back_full = 0;
      end
      if (m_front_valid) begin
        if (m_rem > 0) drop = 1; else launch = 1;
      end
      m_idx = nidx;
    end
    if (m_rem > 0 && led_tready) begin m_rem--; m_wc++; end
    if (launch) begin
      for (int l = 0; l < NO_ARM_LED; l++) m_cur[l] = m_front[nidx][l];
      m_rem = WPS; m_wc = 0;
    end
    if (drop) m_overrun = 1;
    else if (err_clr) m_overrun = 0;
    case (m_phase)
      0: if (frame_req && !bf_old) m_phase = 1;
      1: m_phase = 2;
      default: if (map_out_valid) begin m_back = cur_pix; m_back_full = 1; m_phase = 0; end
    endcase
    m_mrst = (m_phase != 1);
  endtask

  // monitor: compare against the model mid-cycle, then advance the model
  always @(negedge clock) begin
    if (!resetn) model_reset();
    else begin
      chk("tvalid", led_tvalid, m_rem > 0);
      if (m_rem > 0) chk("tdata", led_tdata, exp_word(m_wc));
      chk("tlast", led_tlast, (m_rem > 0) && (m_wc == WPS - 1));
      chk("overrun", overrun, m_overrun);
      chk("frame_loaded", frame_loaded, m_front_valid);
      chk("conv_busy", conv_busy, m_phase != 0);
      chk("map_resetn", map_resetn, m_mrst);
      chk("map_inp_valid", map_inp_valid, m_phase == 2);
      model_step();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_image(input bit rnd);
    for (int i = 0; i < NO_DELTA_INTERVALS; i++)
      for (int l = 0; l < NO_ARM_LED; l++) begin
        cur_pix[i][l] = rnd ? 8'($urandom) : 8'(i*NO_ARM_LED + l);
        map_out_image[(i*NO_ARM_LED + l)*RGB_SIZE +: RGB_SIZE] = cur_pix[i][l];
      end
  endtask

  task automatic convert(input bit rnd, input bit stale);
    int waited;
    frame_req = 1; cyc(1); frame_req = 0;
    chk("clr_resetn_low", map_resetn, 1'b0);
    chk("clr_busy", conv_busy, 1'b1);
    if (stale) begin
      set_image(1);
      map_out_valid = 1;
    end
    cyc(1);
    map_out_valid = 0;
    chk("clr_one_cycle", map_resetn, 1'b1);
    waited = 0;
    while (!map_inp_valid && waited < 8) begin cyc(1); waited++; end
    chk("inp_valid_seen", map_inp_valid, 1'b1);
    cyc(1);
    set_image(rnd);
    map_out_valid = 1; cyc(1); map_out_valid = 0;
    chk("capture_idle", conv_busy, 1'b0);
    chk("capture_inp_drop", map_inp_valid, 1'b0);
  endtask

  task automatic pulse_tick(); angle_tick = 1; cyc(1); angle_tick = 0; endtask
  task automatic pulse_index(); index_pulse = 1; cyc(1); index_pulse = 0; endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_WIDTH-1:0] w [WPS];
    logic                  t [WPS];
    int                    waited;

    set_image(0);
    #17;
    chk("rst_map_resetn", map_resetn, 1'b0);
    chk("rst_tvalid", led_tvalid, 1'b0);
    resetn = 1;
    cyc(1);
    chk("post_rst_map_resetn", map_resetn, 1'b1);
    chk("post_rst_busy", conv_busy, 1'b0);

    // ticks with nothing loaded: no stream, no overrun
    led_tready = 1;
    pulse_tick(); cyc(2); pulse_index(); cyc(2); pulse_tick();
    chk("noframe_tvalid", led_tvalid, 1'b0);
    chk("noframe_overrun", overrun, 1'b0);
    cyc(3);

    // conversion with stale out_valid during the clear cycle
    convert(0, 1);
    frame_req = 1; cyc(1); frame_req = 0;
    chk("full_req_ignored", map_resetn, 1'b1);
    cyc(3);

    // swap and stream slice 0
    pulse_index();
    chk("loaded", frame_loaded, 1'b1);
    chk("s0_valid", led_tvalid, 1'b1);
    for (int k = 0; k < WPS; k++) begin w[k] = led_tdata; t[k] = led_tlast; cyc(1); end
    chk("s0_w0", w[0], 32'h03020100);
    chk("s0_w7", w[WPS-1], 32'h1F1E1D1C);
    chk("s0_tlast7", t[WPS-1], 1'b1);
    chk("s0_tlast6", t[WPS-2], 1'b0);
    chk("s0_done", led_tvalid, 1'b0);
    cyc(3);

    // stalled stream
    pulse_index();
    for (int k = 0; k < 30; k++) begin led_tready = ~led_tready; cyc(1); end
    led_tready = 1; cyc(5);

    // full revolution
    pulse_index(); cyc(10);
    for (int k = 1; k <= NO_DELTA_INTERVALS; k++) begin
      pulse_tick();
      if (k == 5) chk("s5_w0", led_tdata, 32'hA3A2A1A0);
      if (k == NO_DELTA_INTERVALS) chk("wrap_w0", led_tdata, 32'h03020100);
      cyc(10);
    end

    // overrun: idx 0 -> launch 1, drop 2, next tick launches 3
    led_tready = 0;
    pulse_tick(); cyc(3); pulse_tick();
    chk("ovr_set", overrun, 1'b1);
    led_tready = 1; cyc(12);
    chk("ovr_no_extra", led_tvalid, 1'b0);
    pulse_tick();
    chk("ovr_idx_plus2", led_tdata, 32'h63626160);
    cyc(10);
    err_clr = 1; cyc(1); err_clr = 0;
    chk("ovr_clr", overrun, 1'b0);
    led_tready = 0;
    pulse_tick(); cyc(2);
    angle_tick = 1; err_clr = 1; cyc(1); angle_tick = 0; err_clr = 0;
    chk("ovr_drop_wins", overrun, 1'b1);
    cyc(2);

    // asynchronous reset mid-stream
    resetn = 0; #1;
    chk("arst_tvalid", led_tvalid, 1'b0);
    chk("arst_map_resetn", map_resetn, 1'b0);
    chk("arst_inp_valid", map_inp_valid, 1'b0);
    chk("arst_overrun", overrun, 1'b0);
    chk("arst_loaded", frame_loaded, 1'b0);
    cyc(2);
    resetn = 1; cyc(1);
    chk("arst_post_resetn", map_resetn, 1'b1);
    chk("arst_post_busy", conv_busy, 1'b0);
    led_tready = 1;

    // swap with index_pulse and angle_tick together
    convert(1, 0); pulse_index(); cyc(10);
    convert(1, 0); pulse_tick(); cyc(3);
    index_pulse = 1; angle_tick = 1; cyc(1); index_pulse = 0; angle_tick = 0;
    chk("both_valid", led_tvalid, 1'b1);
    cyc(10);
    pulse_tick();
    chk("both_then_idx1", led_tvalid, 1'b1);
    cyc(10);

    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      led_tready    = ($urandom_range(0, 3) != 0);
      angle_tick    = ($urandom_range(0, 5) == 0);
      index_pulse   = ($urandom_range(0, 40) == 0);
      frame_req     = ($urandom_range(0, 30) == 0);
      err_clr       = ($urandom_range(0, 20) == 0);
      map_out_valid = ($urandom_range(0, 2) == 0);
      if (map_out_valid) set_image(1);
      cyc(1);
    end
    angle_tick = 0; index_pulse = 0; frame_req = 0; err_clr = 0; map_out_valid = 0;
    led_tready = 1;
    waited = 0;
    while (led_tvalid && waited < 40) begin cyc(1); waited++; end
    chk("drain", led_tvalid, 1'b0);
    cyc(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
